// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, coefficients, state type and saturation for the FIR datapath
package fir_pkg;
    localparam int N_TAPS = 16;
    localparam int DATA_W = 18;
    localparam int FRAC_W = 15;
    localparam int ACC_W  = 40;
    localparam int PROD_W = 2 * DATA_W;
    localparam int IDX_W  = $clog2(N_TAPS);

    typedef logic [N_TAPS-1:0][DATA_W-1:0] coeff_arr_t;

    // Moving average: every tap is 1/16 in Q3.15
    localparam coeff_arr_t H_COEFFS = {N_TAPS{DATA_W'(2048)}};

    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_W;
        if (sh > ACC_W'(Y_MAX))
            return Y_MAX;
        else if (sh < ACC_W'(Y_MIN))
            return Y_MIN;
        else
            return sh[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - signed 18x18 multiply-accumulate with clear and enable
module fir_mac
    import fir_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [PROD_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/fir_top.sv
// rtl/fir_top.sv - sequential 16-tap direct-form FIR, one tap per clock
module fir_top
    import fir_pkg::*;
#(
    parameter coeff_arr_t H = H_COEFFS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stf_i,
    input  logic signed [DATA_W-1:0] xn_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     eof_o
);
    state_t                   state, state_nxt;
    logic signed [DATA_W-1:0] dline [N_TAPS];
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic                     accept;

    assign accept = (state == IDLE) && stf_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (stf_i) state_nxt = MAC;
            MAC:  if (idx == IDX_W'(N_TAPS - 1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_TAPS; k++)
                dline[k] <= '0;
            idx   <= '0;
            y_o   <= '0;
            eof_o <= 1'b0;
        end else begin
            eof_o <= (state == DONE);
            if (accept) begin
                for (int k = N_TAPS - 1; k > 0; k--)
                    dline[k] <= dline[k-1];
                dline[0] <= xn_i;
                idx      <= '0;
            end else if (state == MAC) begin
                idx <= idx + 1'b1;
            end
            if (state == DONE)
                y_o <= saturate(acc);
        end
    end

    // Accumulator is cleared on the accepting edge so MAC starts from zero
    fir_mac u_mac (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (accept),
        .en    (state == MAC),
        .a     (dline[idx]),
        .b     ($signed(H[idx])),
        .acc   (acc)
    );
endmodule

// File: tb/tb_fir_top.sv
// tb/tb_fir_top.sv - directed self-checking bench for fir_top
module tb_fir_top;
    import fir_pkg::*;

    localparam coeff_arr_t SAT_H = {N_TAPS{DATA_W'(32767)}};

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     stf = 1'b0;
    logic signed [DATA_W-1:0] xn  = '0;
    logic signed [DATA_W-1:0] y, y_sat;
    logic                     eof, eof_sat;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fir_top dut (
        .clk_i (clk), .rst_i (rst), .stf_i (stf), .xn_i (xn), .y_o (y), .eof_o (eof)
    );

    fir_top #(.H(SAT_H)) dut_sat (
        .clk_i (clk), .rst_i (rst), .stf_i (stf), .xn_i (xn), .y_o (y_sat), .eof_o (eof_sat)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after a negedge; the following posedge is E0
    task automatic pulse(input int x);
        stf = 1'b1;
        xn  = x[DATA_W-1:0];
        @(negedge clk);
        stf = 1'b0;
        xn  = '0;
    endtask

    // Called just after E0; returns the edge count at which eof was first seen
    task automatic wait_eof(output int lat);
        lat = 41;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (eof) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run(input int x, input int exp_y, input string tag);
        int lat;
        @(negedge clk);
        pulse(x);
        wait_eof(lat);
        chk({tag, "_lat"}, lat, 17);
        chk({tag, "_y"}, int'(y), exp_y);
    endtask

    initial begin
        int  lat;
        bit  seen;
        longint e;

        // Reset state and a zero sample
        do_reset();
        chk("rst_y", int'(y), 0);
        chk("rst_eof", int'(eof), 0);
        run(0, 0, "zero");
        @(negedge clk);
        chk("zero_eof_width", int'(eof), 0);

        // Impulse response: 16 outputs of 1/16 then zero
        do_reset();
        run(32768, 2048, "imp0");
        for (int i = 1; i <= 20; i++)
            run(0, (i < 16) ? 2048 : 0, $sformatf("imp%0d", i));

        // Step response ramps to unity and stays
        do_reset();
        for (int i = 0; i < 20; i++)
            run(32768, (i < 16) ? 2048 * (i + 1) : 32768, $sformatf("step%0d", i));

        // Truncation toward minus infinity keeps -1 while the sample is in the window
        do_reset();
        run(-1, -1, "neg0");
        for (int i = 1; i < 17; i++)
            run(0, (i < 16) ? -1 : 0, $sformatf("neg%0d", i));

        // Extra strobes at E5 and E17 ignored, strobe at E18 accepted
        do_reset();
        @(negedge clk);
        pulse(32768);
        repeat (4) @(negedge clk);
        stf = 1'b1;
        xn  = DATA_W'(65536);
        @(negedge clk);
        stf = 1'b0;
        repeat (11) @(negedge clk);
        chk("hs_eof_e16", int'(eof), 0);
        stf = 1'b1;
        @(negedge clk);
        chk("hs_eof_e17", int'(eof), 1);
        chk("hs_y_e17", int'(y), 2048);
        xn = '0;
        @(negedge clk);
        stf = 1'b0;
        chk("hs_eof_e18", int'(eof), 0);
        wait_eof(lat);
        chk("hs_e18_lat", lat, 17);
        chk("hs_e18_y", int'(y), 2048);

        // Reset at E8 discards the result and clears the delay line
        do_reset();
        run(32768, 2048, "mid_pre");
        @(negedge clk);
        pulse(32768);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_y", int'(y), 0);
        chk("mid_eof", int'(eof), 0);
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (eof) seen = 1'b1;
        end
        chk("mid_no_eof", int'(seen), 0);
        run(0, 0, "mid_cleared");

        // Full-scale positive and negative, with a saturating coefficient set alongside
        do_reset();
        for (int i = 0; i < 16; i++) begin
            e = (longint'(i + 1) * 131071 * 2048) >>> 15;
            run(131071, int'(e), $sformatf("pos%0d", i));
        end
        chk("sat_pos", int'(y_sat), 131071);
        do_reset();
        for (int i = 0; i < 16; i++)
            run(-131072, -8192 * (i + 1), $sformatf("min%0d", i));
        chk("sat_neg", int'(y_sat), -131072);
        chk("sat_eof", int'(eof_sat), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
